// File: rtl/spiro_sequencer.sv
// spiro_sequencer: master controller for one spirometer measurement cycle.
// The cycle runs IDLE -> COUNTDOWN -> MEASURE -> RESULT -> IDLE.
// It also produces the display code, the display load strobe and the BCD digits.
//
// Ports:
//   iClk           system clock
//   iReset         synchronous, active-high reset
//   iStart         start button level, asynchronous (2-flop synchronised here)
//   iAbort         abort level, synchronous; returns to IDLE on the next edge
//   iFlowPulse     one-cycle pulse per flow-sensor increment
//   ovStateMachine display code: 0=COUNTDOWN 1=MEASURE 2=RESULT 3=IDLE
//   oDisplayCE     one-cycle display load strobe
//   ovCount1/2     countdown tens/units, BCD
//   ovFlow1..4     flow thousands/hundreds/tens/units, BCD
//   oBusy          high in COUNTDOWN or MEASURE
//   oDone          one-cycle pulse on MEASURE -> RESULT
//
// Optional feature: define SPIRO_START_DEBOUNCE_EN so that the synchronised
// start input must be held high for DEBOUNCE_CYC cycles before a start event
// is issued. Without it, the start event is the synchronised rising edge.
module spiro_sequencer #(
    parameter int unsigned TICK_DIV      = 50_000_000,
    parameter int unsigned COUNTDOWN_SEC = 5,
    parameter int unsigned MEASURE_SEC   = 6,
    parameter int unsigned RESULT_SEC    = 10,
    parameter int unsigned DISP_CE_DIV   = 5_000_000,
    parameter int unsigned DEBOUNCE_CYC  = 500_000
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iAbort,
    input  logic       iFlowPulse,
    output logic [1:0] ovStateMachine,
    output logic       oDisplayCE,
    output logic [3:0] ovCount1,
    output logic [3:0] ovCount2,
    output logic [3:0] ovFlow1,
    output logic [3:0] ovFlow2,
    output logic [3:0] ovFlow3,
    output logic [3:0] ovFlow4,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [1:0] {
        ST_COUNTDOWN = 2'd0,
        ST_MEASURE   = 2'd1,
        ST_RESULT    = 2'd2,
        ST_IDLE      = 2'd3
    } state_t;

    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CE_W     = (DISP_CE_DIV > 1) ? $clog2(DISP_CE_DIV) : 1;
    localparam logic [3:0]  CD_TENS  = 4'(COUNTDOWN_SEC / 10);
    localparam logic [3:0]  CD_UNITS = 4'(COUNTDOWN_SEC % 10);

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [CE_W-1:0]   ce_cnt;
    logic              ce_wrap;
    logic [7:0]        sec_cnt;
    logic [3:0]        cnt_tens;
    logic [3:0]        cnt_units;
    logic [15:0]       flow;
    logic              busy;
    logic              done;
    logic              disp_ce;
    logic              state_chg;
    logic [1:0]        sync_ff;
    logic              start_evt;

    // Saturating 4-digit BCD increment with ripple carry.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous start button.
    always_ff @(posedge iClk) begin
        if (iReset) sync_ff <= '0;
        else        sync_ff <= {sync_ff[0], iStart};
    end

`ifdef SPIRO_START_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    logic [DB_W-1:0] db_cnt;
    logic            db_fired;

    // One event per press, after DEBOUNCE_CYC consecutive high cycles.
    always_ff @(posedge iClk) begin
        if (iReset || !sync_ff[1]) begin
            db_cnt   <= '0;
            db_fired <= 1'b0;
        end else if (!db_fired) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) db_fired <= 1'b1;
            else                                   db_cnt   <= db_cnt + DB_W'(1);
        end
    end

    assign start_evt = sync_ff[1] & ~db_fired & (db_cnt == DB_W'(DEBOUNCE_CYC - 1));
`else
    logic start_prev;

    // Rising edge of the synchronised start level.
    always_ff @(posedge iClk) begin
        if (iReset) start_prev <= 1'b0;
        else        start_prev <= sync_ff[1];
    end

    assign start_evt = sync_ff[1] & ~start_prev;
`endif

    assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign ce_wrap = (ce_cnt == CE_W'(DISP_CE_DIV - 1));

    // Free-running display refresh divider.
    always_ff @(posedge iClk) begin
        if (iReset) ce_cnt <= '0;
        else        ce_cnt <= ce_wrap ? '0 : ce_cnt + CE_W'(1);
    end

    // Sequencer. Every state change clears the tick divider and second
    // counter, raises state_chg for one cycle (which becomes the display
    // strobe a cycle later) and drops a refresh pulse that would otherwise
    // sit right next to that strobe.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            sec_cnt   <= '0;
            cnt_tens  <= '0;
            cnt_units <= '0;
            flow      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            disp_ce   <= 1'b0;
            state_chg <= 1'b0;
        end else begin
            done      <= 1'b0;
            state_chg <= 1'b0;
            disp_ce   <= state_chg | (ce_wrap & ~disp_ce);
            tick_cnt  <= tick ? '0 : tick_cnt + TICK_W'(1);

            if (iAbort) begin
                cnt_tens  <= '0;
                cnt_units <= '0;
                busy      <= 1'b0;
                if (state != ST_IDLE) begin
                    state     <= ST_IDLE;
                    tick_cnt  <= '0;
                    sec_cnt   <= '0;
                    state_chg <= 1'b1;
                    disp_ce   <= state_chg;
                end
            end else if (start_evt && (state == ST_IDLE || state == ST_RESULT)) begin
                tick_cnt  <= '0;
                sec_cnt   <= '0;
                busy      <= 1'b1;
                state_chg <= 1'b1;
                disp_ce   <= state_chg;
                if (COUNTDOWN_SEC == 0) begin
                    state     <= ST_MEASURE;
                    cnt_tens  <= '0;
                    cnt_units <= '0;
                    flow      <= '0;
                end else begin
                    state     <= ST_COUNTDOWN;
                    cnt_tens  <= CD_TENS;
                    cnt_units <= CD_UNITS;
                end
            end else if (tick) begin
                unique case (state)
                    ST_COUNTDOWN: begin
                        if (cnt_tens == 4'd0 && cnt_units == 4'd1) begin
                            state     <= ST_MEASURE;
                            cnt_units <= 4'd0;
                            flow      <= '0;
                            tick_cnt  <= '0;
                            sec_cnt   <= '0;
                            state_chg <= 1'b1;
                            disp_ce   <= state_chg;
                        end else if (cnt_units == 4'd0) begin
                            cnt_units <= 4'd9;
                            cnt_tens  <= cnt_tens - 4'd1;
                        end else begin
                            cnt_units <= cnt_units - 4'd1;
                        end
                    end
                    ST_MEASURE: begin
                        if (iFlowPulse) flow <= bcd_inc(flow);
                        if (sec_cnt == 8'(MEASURE_SEC - 1)) begin
                            state     <= ST_RESULT;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            tick_cnt  <= '0;
                            sec_cnt   <= '0;
                            state_chg <= 1'b1;
                            disp_ce   <= state_chg;
                        end else begin
                            sec_cnt <= sec_cnt + 8'd1;
                        end
                    end
                    ST_RESULT: begin
                        if (sec_cnt == 8'(RESULT_SEC - 1)) begin
                            state     <= ST_IDLE;
                            tick_cnt  <= '0;
                            sec_cnt   <= '0;
                            state_chg <= 1'b1;
                            disp_ce   <= state_chg;
                        end else begin
                            sec_cnt <= sec_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (state == ST_MEASURE && iFlowPulse) begin
                flow <= bcd_inc(flow);
            end
        end
    end

    assign ovStateMachine = state;
    assign oDisplayCE     = disp_ce;
    assign ovCount1       = cnt_tens;
    assign ovCount2       = cnt_units;
    assign ovFlow1        = flow[15:12];
    assign ovFlow2        = flow[11:8];
    assign ovFlow3        = flow[7:4];
    assign ovFlow4        = flow[3:0];
    assign oBusy          = busy;
    assign oDone          = done;

endmodule

// File: tb/tb_spiro_sequencer.sv
// Testbench for spiro_sequencer: randomized pulse patterns and sample points,
// checked against expected values computed from elapsed seconds and pulse counts.
module tb_spiro_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, abort, flow;
    logic [1:0] st;
    logic ce, busy, done;
    logic [3:0] c1, c2, f1, f2, f3, f4;

    logic start_b, abort_b, flow_b;
    logic [1:0] st_b;
    logic ce_b, busy_b, done_b;
    logic [3:0] c1_b, c2_b, f1_b, f2_b, f3_b, f4_b;

    logic start_c;
    logic [1:0] st_c;
    logic ce_c, busy_c, done_c;
    logic [3:0] c1_c, c2_c, f1_c, f2_c, f3_c, f4_c;

    spiro_sequencer #(.TICK_DIV(10), .COUNTDOWN_SEC(3), .MEASURE_SEC(2), .RESULT_SEC(2),
                      .DISP_CE_DIV(4), .DEBOUNCE_CYC(4)) dut (
        .iClk(clk), .iReset(rst), .iStart(start), .iAbort(abort), .iFlowPulse(flow),
        .ovStateMachine(st), .oDisplayCE(ce), .ovCount1(c1), .ovCount2(c2),
        .ovFlow1(f1), .ovFlow2(f2), .ovFlow3(f3), .ovFlow4(f4), .oBusy(busy), .oDone(done));

    spiro_sequencer #(.TICK_DIV(50), .COUNTDOWN_SEC(10), .MEASURE_SEC(255), .RESULT_SEC(2),
                      .DISP_CE_DIV(4), .DEBOUNCE_CYC(4)) dut_b (
        .iClk(clk), .iReset(rst), .iStart(start_b), .iAbort(abort_b), .iFlowPulse(flow_b),
        .ovStateMachine(st_b), .oDisplayCE(ce_b), .ovCount1(c1_b), .ovCount2(c2_b),
        .ovFlow1(f1_b), .ovFlow2(f2_b), .ovFlow3(f3_b), .ovFlow4(f4_b), .oBusy(busy_b), .oDone(done_b));

    spiro_sequencer #(.TICK_DIV(10), .COUNTDOWN_SEC(0), .MEASURE_SEC(2), .RESULT_SEC(2),
                      .DISP_CE_DIV(4), .DEBOUNCE_CYC(4)) dut_c (
        .iClk(clk), .iReset(rst), .iStart(start_c), .iAbort(1'b0), .iFlowPulse(1'b0),
        .ovStateMachine(st_c), .oDisplayCE(ce_c), .ovCount1(c1_c), .ovCount2(c2_c),
        .ovFlow1(f1_c), .ovFlow2(f2_c), .ovFlow3(f3_c), .ovFlow4(f4_c), .oBusy(busy_c), .oDone(done_c));

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Expected display digits, packed one BCD digit per nibble.
    function automatic int bcd2(input int v);
        return ((v / 10) % 10) * 16 + v % 10;
    endfunction

    function automatic int bcd4(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return ((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + s % 10;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int cur_st(input int sel);
        case (sel)
            1:       return int'(st_b);
            2:       return int'(st_c);
            default: return int'(st);
        endcase
    endfunction

    task automatic wait_state(input int sel, input int target, input int budget, output int waited);
        waited = 0;
        while (cur_st(sel) != target && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Display strobe monitor: one cycle wide, and present the cycle after each transition.
    bit mon_en = 1'b0;
    logic [1:0] prev_st = 2'd3;
    logic prev_ce = 1'b0;
    logic prev_rst = 1'b1;
    bit chg_seen = 1'b0;

    always @(negedge clk) begin
        #2;
        if (mon_en && !prev_rst) begin
            if (chg_seen) check("ce_after_change", int'(ce), 1);
            if (prev_ce)  check("ce_single_cycle", int'(ce), 0);
        end
        chg_seen = mon_en && (st != prev_st) && !prev_rst;
        prev_st  = st;
        prev_ce  = ce;
        prev_rst = rst;
    end

    // Full press -> countdown -> measure -> result sequence on the main DUT.
    // When restart is set, a press in RESULT must restart the countdown.
    task automatic measure_cycle(input int npulse, input bit restart);
        bit pat[20];
        int w, off, idx;
        for (int i = 0; i < 20; i++) pat[i] = 1'b0;
        for (int i = 0; i < npulse; i++) begin
            idx = int'($urandom_range(0, 19));
            while (pat[idx]) idx = (idx + 1) % 20;
            pat[idx] = 1'b1;
        end

        start = 1'b1;
        wait_state(0, 0, 8, w);
        check("start_latency", w, 3);
        check("cd_entry_state", int'(st), 0);
        check("cd_entry_busy", int'(busy), 1);
        start = 1'b0;

        for (int k = 0; k < 3; k++) begin
            off = int'($urandom_range(0, 9));
            cyc(off);
            check("cd_digits", int'({c1, c2}), bcd2(3 - k));
            check("cd_state", int'(st), 0);
            cyc(10 - off);
        end
        check("meas_entry_state", int'(st), 1);
        check("meas_entry_busy", int'(busy), 1);
        check("meas_entry_digits", int'({c1, c2}), 0);
        check("meas_entry_flow", int'({f1, f2, f3, f4}), 0);

        for (int j = 0; j < 20; j++) begin
            flow = pat[j];
            if (j == 5) start = 1'b1;
            if (j == 19) begin
                check("meas_last_state", int'(st), 1);
                check("meas_last_done", int'(done), 0);
            end
            cyc(1);
        end
        flow = 1'b0;
        check("result_state", int'(st), 2);
        check("result_done", int'(done), 1);
        check("result_busy", int'(busy), 0);
        check("result_flow", int'({f1, f2, f3, f4}), bcd4(npulse));
        cyc(1);
        start = 1'b0;
        check("done_width", int'(done), 0);
        check("result_hold_state", int'(st), 2);

        if (restart) begin
            cyc(3);
            start = 1'b1;
            wait_state(0, 0, 8, w);
            check("restart_latency", w, 3);
            check("restart_state", int'(st), 0);
            check("restart_digits", int'({c1, c2}), bcd2(3));
            check("restart_flow_held", int'({f1, f2, f3, f4}), bcd4(npulse));
            start = 1'b0;
        end else begin
            cyc(18);
            check("result_end_state", int'(st), 2);
            cyc(1);
            check("idle_state", int'(st), 3);
            check("idle_flow_held", int'({f1, f2, f3, f4}), bcd4(npulse));
            check("idle_busy", int'(busy), 0);
        end
    endtask

    initial begin
        int cnt, w, k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; flow = 1'b0;
        start_b = 1'b0; abort_b = 1'b0; flow_b = 1'b0; start_c = 1'b0;
        cyc(3);
        check("rst_state", int'(st), 3);
        check("rst_digits", int'({c1, c2}), 0);
        check("rst_flow", int'({f1, f2, f3, f4}), 0);
        check("rst_ce", int'(ce), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            cnt += int'(ce);
        end
        check("ce_period_count", cnt, 10);

        measure_cycle(12, 1'b0);
        for (int it = 0; it < 3; it++) measure_cycle(int'($urandom_range(0, 20)), 1'b0);
        measure_cycle(int'($urandom_range(0, 20)), 1'b1);

        // Abort in the middle of MEASURE.
        wait_state(0, 1, 40, w);
        check("abort_meas_state", int'(st), 1);
        check("abort_meas_flow_clear", int'({f1, f2, f3, f4}), 0);
        k = int'($urandom_range(1, 8));
        for (int j = 0; j < k; j++) begin
            flow = 1'b1;
            cyc(1);
        end
        flow = 1'b0;
        cyc(2);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_state", int'(st), 3);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_digits", int'({c1, c2}), 0);
        check("abort_flow_kept", int'({f1, f2, f3, f4}), bcd4(k));
        for (int i = 0; i < 25; i++) begin
            cyc(1);
            check("abort_no_done", int'(done), 0);
        end
        check("abort_stays_idle", int'(st), 3);

        // Reset in the middle of COUNTDOWN.
        start = 1'b1;
        wait_state(0, 0, 8, w);
        check("rst2_cd_state", int'(st), 0);
        start = 1'b0;
        cyc(int'($urandom_range(2, 8)));
        rst = 1'b1;
        cyc(1);
        check("rst2_state", int'(st), 3);
        check("rst2_digits", int'({c1, c2}), 0);
        check("rst2_flow", int'({f1, f2, f3, f4}), 0);
        check("rst2_busy", int'(busy), 0);
        check("rst2_ce", int'(ce), 0);
        check("rst2_done", int'(done), 0);
        rst = 1'b0;
        cyc(2);

        // COUNTDOWN_SEC=0: start goes straight to MEASURE.
        start_c = 1'b1;
        wait_state(2, 1, 8, w);
        check("c_latency", w, 3);
        check("c_state", int'(st_c), 1);
        check("c_busy", int'(busy_c), 1);
        check("c_digits", int'({c1_c, c2_c}), 0);
        start_c = 1'b0;

        // COUNTDOWN_SEC=10 borrow and 9999 saturation.
        start_b = 1'b1;
        wait_state(1, 0, 8, w);
        check("b_latency", w, 3);
        check("b_digits_10", int'({c1_b, c2_b}), bcd2(10));
        start_b = 1'b0;
        cyc(50);
        check("b_digits_09", int'({c1_b, c2_b}), bcd2(9));
        cyc(449);
        check("b_digits_01", int'({c1_b, c2_b}), bcd2(1));
        check("b_cd_state", int'(st_b), 0);
        cyc(1);
        check("b_meas_state", int'(st_b), 1);
        for (int i = 1; i <= 10005; i++) begin
            flow_b = 1'b1;
            cyc(1);
            if (i == 9998 || i == 9999 || i == 10005)
                check("b_flow_sat", int'({f1_b, f2_b, f3_b, f4_b}), bcd4(i));
        end
        flow_b = 1'b0;
        check("b_still_meas", int'(st_b), 1);
        abort_b = 1'b1;
        cyc(1);
        abort_b = 1'b0;
        check("b_abort_state", int'(st_b), 3);
        check("b_abort_done", int'(done_b), 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
